// File: rtl/modbus_pkg.sv
// Shared constants, state encoding and CRC-16/Modbus bit step for the
// Modbus RTU frame receiver.
package modbus_pkg;

  localparam logic [15:0] MB_CRC_POLY     = 16'hA001;
  localparam logic [15:0] MB_CRC_INIT     = 16'hFFFF;
  localparam int unsigned MB_FRAME_LEN    = 7;
  localparam logic [7:0]  MB_FUNC_RD_HOLD = 8'h03;
  localparam logic [7:0]  MB_BYTE_COUNT   = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CRC,
    CHECK
  } mb_state_t;

  function automatic logic [15:0] mb_crc_step(input logic [15:0] c);
    return (c >> 1) ^ (c[0] ? MB_CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/modbus_frame_rx_if.sv
// Byte handshake between the UART receiver (master) and the frame assembler (slave).
interface modbus_frame_rx_if;

  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;

  modport master (output RX_Done_Sig, output RX_Data, input RX_En_Sig);
  modport slave  (input RX_Done_Sig, input RX_Data, output RX_En_Sig);

endinterface

// File: rtl/crc16_modbus_serial.sv
// Bit-serial CRC-16/Modbus: one shift step per cycle while step=1; the caller
// presents the data byte on the first step of each byte and zero afterwards.
module crc16_modbus_serial
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      crc <= MB_CRC_INIT;
    end else if (step) begin
      crc <= mb_crc_step(crc ^ {8'h00, data});
    end
  end

endmodule

// File: rtl/modbus_frame_rx.sv
// Assembles 7-byte Modbus RTU read-holding-register responses, checks CRC,
// slave address and format, enforces the 3.5-char silence timeout.
module modbus_frame_rx
  import modbus_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR = 8'h01,
  parameter int unsigned T35_CYCLES = 200_000
) (
  input  logic              CLK,
  input  logic              RST,
  modbus_frame_rx_if.slave  rx,
  output logic [15:0]       Frame_Data,
  output logic              Frame_Valid_Sig,
  output logic              CRC_Err_Sig,
  output logic              Format_Err_Sig,
  output logic              Timeout_Err_Sig
);

  localparam int unsigned TW = $clog2(T35_CYCLES + 1);
  // Compare two counts early so the registered pulse lands at last accept + 8 + T35.
  localparam logic [TW-1:0] TIMEOUT_AT = TW'(T35_CYCLES - 2);

  mb_state_t     state;
  logic [2:0]    byte_cnt;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    cur_byte;
  logic [7:0]    hdr [5];

  logic          accept;
  logic          timeout_hit;
  logic          crc_load;
  logic          crc_step_en;
  logic [7:0]    crc_data;
  logic [15:0]   crc;

  always_comb begin
    accept      = rx.RX_Done_Sig && rx.RX_En_Sig;
    timeout_hit = (state == WAIT) && (timer == TIMEOUT_AT);
    crc_load    = (state == IDLE) || (state == CHECK) || timeout_hit;
    crc_step_en = (state == CRC);
    crc_data    = (bit_cnt == 3'd0) ? cur_byte : '0;
  end

  crc16_modbus_serial u_crc (
    .clk  (CLK),
    .rst  (RST),
    .load (crc_load),
    .step (crc_step_en),
    .data (crc_data),
    .crc  (crc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      byte_cnt        <= '0;
      bit_cnt         <= '0;
      timer           <= '0;
      cur_byte        <= '0;
      for (int unsigned i = 0; i < 5; i++) hdr[i] <= '0;
      rx.RX_En_Sig    <= 1'b0;
      Frame_Data      <= '0;
      Frame_Valid_Sig <= 1'b0;
      CRC_Err_Sig     <= 1'b0;
      Format_Err_Sig  <= 1'b0;
      Timeout_Err_Sig <= 1'b0;
    end else begin
      Frame_Valid_Sig <= 1'b0;
      CRC_Err_Sig     <= 1'b0;
      Format_Err_Sig  <= 1'b0;
      Timeout_Err_Sig <= 1'b0;
      unique case (state)
        IDLE: begin
          byte_cnt     <= '0;
          bit_cnt      <= '0;
          timer        <= '0;
          rx.RX_En_Sig <= 1'b1;
          if (accept) begin
            hdr[0]       <= rx.RX_Data;
            cur_byte     <= rx.RX_Data;
            byte_cnt     <= 3'd1;
            rx.RX_En_Sig <= 1'b0;
            state        <= CRC;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          // Silence wins over a byte arriving on the same cycle; that byte is dropped.
          if (timeout_hit) begin
            Timeout_Err_Sig <= 1'b1;
            timer           <= '0;
            byte_cnt        <= '0;
            state           <= IDLE;
          end else if (accept) begin
            if (byte_cnt < 3'd5) hdr[byte_cnt] <= rx.RX_Data;
            cur_byte     <= rx.RX_Data;
            byte_cnt     <= byte_cnt + 1'b1;
            timer        <= '0;
            rx.RX_En_Sig <= 1'b0;
            state        <= CRC;
          end
        end
        CRC: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == 3'(MB_FRAME_LEN)) begin
              state <= CHECK;
            end else begin
              rx.RX_En_Sig <= 1'b1;
              state        <= WAIT;
            end
          end
        end
        CHECK: begin
          if (crc != '0) begin
            CRC_Err_Sig <= 1'b1;
          end else if (hdr[0] == SLAVE_ADDR) begin
            if (hdr[1] != MB_FUNC_RD_HOLD || hdr[2] != MB_BYTE_COUNT) begin
              Format_Err_Sig <= 1'b1;
            end else begin
              Frame_Data      <= {hdr[3], hdr[4]};
              Frame_Valid_Sig <= 1'b1;
            end
          end
          byte_cnt     <= '0;
          rx.RX_En_Sig <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_rx.sv
// Directed bench for modbus_frame_rx: table of frames with hand-derived
// outcomes, plus timeout, ignored-byte and mid-frame reset sequences.
module tb_modbus_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] frame_data;
  logic        valid, crc_err, fmt_err, to_err;

  modbus_frame_rx_if ifc ();

  modbus_frame_rx #(.SLAVE_ADDR(8'h01), .T35_CYCLES(100)) dut (
    .CLK             (clk),
    .RST             (rst),
    .rx              (ifc),
    .Frame_Data      (frame_data),
    .Frame_Valid_Sig (valid),
    .CRC_Err_Sig     (crc_err),
    .Format_Err_Sig  (fmt_err),
    .Timeout_Err_Sig (to_err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] frame_t [7];
  typedef struct {
    frame_t      b;
    logic        v;
    logic        c;
    logic        f;
    logic [15:0] data;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_valid = 0, n_crc = 0, n_fmt = 0, n_to = 0;
  int unsigned e_valid = 0, e_crc = 0, e_fmt = 0, e_to = 0;

  // Count every high cycle of each pulse so a stuck or stretched pulse shows up.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid)   n_valid++;
      if (crc_err) n_crc++;
      if (fmt_err) n_fmt++;
      if (to_err)  n_to++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic v, input logic c, input logic f,
                            input logic t, input logic [15:0] d, input logic en);
    check({name, "_valid"}, {15'd0, valid}, {15'd0, v});
    check({name, "_crc"},   {15'd0, crc_err}, {15'd0, c});
    check({name, "_fmt"},   {15'd0, fmt_err}, {15'd0, f});
    check({name, "_to"},    {15'd0, to_err}, {15'd0, t});
    check({name, "_data"},  frame_data, d);
    check({name, "_en"},    {15'd0, ifc.RX_En_Sig}, {15'd0, en});
  endtask

  // Called at a falling edge; returns at the falling edge one cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    while (!ifc.RX_En_Sig && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.RX_En_Sig) check("en_wait", {15'd0, ifc.RX_En_Sig}, 16'd1);
    ifc.RX_Data     = b;
    ifc.RX_Done_Sig = 1'b1;
    @(negedge clk);
    ifc.RX_Done_Sig = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    for (int i = 0; i < 7; i++) send_byte(f[i]);
  endtask

  function automatic frame_t mk(input logic [7:0] a, input logic [7:0] fn, input logic [7:0] n,
                                input logic [7:0] h, input logic [7:0] l);
    logic [15:0] c;
    logic [7:0]  bs [5];
    frame_t      r;
    bs = '{a, fn, n, h, l};
    c  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      c = c ^ {8'h00, bs[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    r = '{a, fn, n, h, l, c[7:0], c[15:8]};
    return r;
  endfunction

  function automatic vec_t mkv(input frame_t b, input logic v, input logic c, input logic f,
                               input logic [15:0] d);
    vec_t x;
    x.b = b; x.v = v; x.c = c; x.f = f; x.data = d;
    return x;
  endfunction

  vec_t   vecs [9];
  frame_t s1;

  initial begin
    rst             = 1'b1;
    ifc.RX_Done_Sig = 1'b0;
    ifc.RX_Data     = 8'h00;
    s1              = '{8'h01, 8'h03, 8'h02, 8'h00, 8'h0A, 8'h38, 8'h43};

    vecs[0] = mkv(s1, 1'b1, 1'b0, 1'b0, 16'h000A);
    vecs[1] = mkv('{8'h01, 8'h03, 8'h02, 8'h00, 8'h0B, 8'h38, 8'h43}, 1'b0, 1'b1, 1'b0, 16'h000A);
    vecs[2] = mkv(mk(8'h02, 8'h03, 8'h02, 8'h00, 8'h0A), 1'b0, 1'b0, 1'b0, 16'h000A);
    vecs[3] = mkv(mk(8'h01, 8'h04, 8'h02, 8'h00, 8'h0A), 1'b0, 1'b0, 1'b1, 16'h000A);
    vecs[4] = mkv(mk(8'h01, 8'h03, 8'h04, 8'h00, 8'h0A), 1'b0, 1'b0, 1'b1, 16'h000A);
    vecs[5] = mkv(mk(8'h01, 8'h03, 8'h02, 8'hAB, 8'hCD), 1'b1, 1'b0, 1'b0, 16'hABCD);
    vecs[6] = mkv('{8'h01, 8'h03, 8'h02, 8'h00, 8'h0A, 8'h38, 8'h42}, 1'b0, 1'b1, 1'b0, 16'hABCD);
    vecs[7] = mkv(mk(8'h7F, 8'h03, 8'h02, 8'h11, 8'h22), 1'b0, 1'b0, 1'b0, 16'hABCD);
    vecs[8] = mkv(s1, 1'b1, 1'b0, 1'b0, 16'h000A);

    repeat (3) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("en_after_reset", {15'd0, ifc.RX_En_Sig}, 16'd1);

    // Back-to-back frames: the next frame starts as soon as the enable returns.
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].b);
      repeat (8) @(negedge clk);
      check_outs($sformatf("v%0d_t9", i), 1'b0, 1'b0, 1'b0, 1'b0, vecs[i].data == 16'hABCD && i == 5 ? 16'h000A : (i == 8 ? 16'hABCD : (i == 0 ? 16'h0000 : (i >= 6 ? 16'hABCD : 16'h000A))), 1'b0);
      @(negedge clk);
      check_outs($sformatf("v%0d_t10", i), vecs[i].v, vecs[i].c, vecs[i].f, 1'b0, vecs[i].data, 1'b1);
      if (vecs[i].v) e_valid++;
      if (vecs[i].c) e_crc++;
      if (vecs[i].f) e_fmt++;
    end

    // Partial frame then silence; a byte on the detection cycle is dropped.
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h02);
    repeat (106) @(negedge clk);
    check("to_a107", {15'd0, to_err}, 16'd0);
    ifc.RX_Data     = 8'h01;
    ifc.RX_Done_Sig = 1'b1;
    @(negedge clk);
    ifc.RX_Done_Sig = 1'b0;
    check("to_a108", {15'd0, to_err}, 16'd1);
    e_to++;
    @(negedge clk);
    check("to_a109", {15'd0, to_err}, 16'd0);
    send_frame(s1);
    repeat (9) @(negedge clk);
    check_outs("after_to", 1'b1, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b1);
    e_valid++;

    // Done pulse while the receiver is disabled during the CRC window.
    send_byte(8'h01);
    @(negedge clk);
    check("crc_win_en", {15'd0, ifc.RX_En_Sig}, 16'd0);
    ifc.RX_Data     = 8'h55;
    ifc.RX_Done_Sig = 1'b1;
    @(negedge clk);
    ifc.RX_Done_Sig = 1'b0;
    for (int i = 1; i < 7; i++) send_byte(s1[i]);
    repeat (9) @(negedge clk);
    check_outs("ign_byte", 1'b1, 1'b0, 1'b0, 1'b0, 16'h000A, 1'b1);
    e_valid++;

    // Reset coincident with byte 4, then a fresh frame.
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h02);
    while (!ifc.RX_En_Sig) @(negedge clk);
    ifc.RX_Data     = 8'h00;
    ifc.RX_Done_Sig = 1'b1;
    rst             = 1'b1;
    @(negedge clk);
    ifc.RX_Done_Sig = 1'b0;
    check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_en", {15'd0, ifc.RX_En_Sig}, 16'd1);
    send_frame(mk(8'h01, 8'h03, 8'h02, 8'h12, 8'h34));
    repeat (9) @(negedge clk);
    check_outs("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1);
    e_valid++;

    repeat (3) @(negedge clk);
    check("tot_valid", 16'(n_valid), 16'(e_valid));
    check("tot_crc",   16'(n_crc),   16'(e_crc));
    check("tot_fmt",   16'(n_fmt),   16'(e_fmt));
    check("tot_to",    16'(n_to),    16'(e_to));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
